// File: rtl/ecall_pkg.sv
// Shared definitions for the ecall I/O unit: service codes, FSM state encoding
// and the ecall opcode.
package ecall_pkg;

    localparam logic [31:0] ECALL_OPCODE  = 32'h0000_0073;

    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_READ_INT  = 32'd5;
    localparam logic [31:0] SVC_EXIT      = 32'd10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_REL   = 3'd1,
        WAIT_PRESS = 3'd2,
        DEBOUNCE   = 3'd3,
        WRITEBACK  = 3'd4,
        HALT       = 3'd5
    } state_t;

    function automatic logic is_ecall(input logic [31:0] instr);
        return instr == ECALL_OPCODE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Confirm-button debouncer: counts consecutive high cycles while armed and
// flags a stable press once DEBOUNCE_CYCLES is reached.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic arm,
    output logic pressed,
    output logic released
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!arm) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= cnt;                 // saturate, never wrap
        end else if (!btn) begin
            cnt <= '0;                  // bounce restarts the full count
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign pressed  = arm && (cnt == CNT_MAX);
    assign released = ~btn;

endmodule

// File: rtl/ecall_io_unit.sv
// ecall service unit for the single-cycle RV32 core: PRINT_INT, READ_INT, EXIT.
// Define ECALL_SIGNED_READ_EN to sign-extend switch reads (default: zero-extend).
module ecall_io_unit
    import ecall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SW_W            = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ecall_valid,
    input  logic [31:0]     a7,
    input  logic [31:0]     a0,
    input  logic [SW_W-1:0] sw_in,
    input  logic            confirm_btn,
    output logic            stall,
    output logic            wb_valid,
    output logic [31:0]     wb_data,
    output logic [31:0]     disp_data,
    output logic            disp_update,
    output logic            halted
);

    state_t state, state_n;

    logic        stall_c;
    logic        do_print;
    logic        do_capture;
    logic        arm;
    logic        pressed;
    logic        released;
    logic        ext_fill;
    logic [31:0] sw_ext;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn     (confirm_btn),
        .arm     (arm),
        .pressed (pressed),
        .released(released)
    );

`ifdef ECALL_SIGNED_READ_EN
    assign ext_fill = sw_in[SW_W-1];
`else
    assign ext_fill = 1'b0;
`endif

    // Per-bit generate keeps SW_W == 32 legal (no zero-width replication).
    for (genvar i = 0; i < 32; i++) begin : g_ext
        if (i < SW_W) begin : g_sw
            assign sw_ext[i] = sw_in[i];
        end else begin : g_fill
            assign sw_ext[i] = ext_fill;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_n    = state;
        stall_c    = 1'b0;
        wb_valid   = 1'b0;
        do_print   = 1'b0;
        do_capture = 1'b0;
        arm        = 1'b0;

        case (state)
            IDLE: begin
                if (ecall_valid) begin
                    if (a7 == SVC_PRINT_INT) begin
                        do_print = 1'b1;
                    end else if (a7 == SVC_READ_INT) begin
                        stall_c = 1'b1;
                        state_n = WAIT_REL;
                    end else if (a7 == SVC_EXIT) begin
                        state_n = HALT;
                    end
                end
            end
            WAIT_REL: begin
                stall_c = 1'b1;
                if (released) state_n = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                stall_c = 1'b1;
                arm     = 1'b1;
                if (confirm_btn) state_n = DEBOUNCE;
            end
            DEBOUNCE: begin
                stall_c = 1'b1;
                arm     = 1'b1;
                if (pressed) begin
                    do_capture = 1'b1;
                    state_n    = WRITEBACK;
                end else if (released) begin
                    state_n = WAIT_PRESS;
                end
            end
            WRITEBACK: begin
                wb_valid = 1'b1;
                state_n  = IDLE;
            end
            HALT: begin
                stall_c = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Gated by reset so the core is released the instant reset asserts.
    assign stall  = stall_c & reset;
    assign halted = (state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data     <= '0;
            disp_data   <= '0;
            disp_update <= 1'b0;
        end else begin
            disp_update <= do_print;
            if (do_print)   disp_data <= a0;
            if (do_capture) wb_data   <= sw_ext;
        end
    end

endmodule

// File: tb/tb_ecall_io_unit.sv
// Directed testbench for ecall_io_unit (DEBOUNCE_CYCLES=4, SW_W=16).
module tb_ecall_io_unit;

    localparam int DEB  = 4;
    localparam int SW_W = 16;

`ifdef ECALL_SIGNED_READ_EN
    localparam logic [31:0] RD_FFFE = 32'hFFFF_FFFE;
    localparam logic [31:0] RD_8001 = 32'hFFFF_8001;
`else
    localparam logic [31:0] RD_FFFE = 32'h0000_FFFE;
    localparam logic [31:0] RD_8001 = 32'h0000_8001;
`endif
    localparam logic [31:0] RD_1234 = 32'h0000_1234;
    localparam logic [31:0] BEEF    = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            reset;
    logic            ecall_valid;
    logic [31:0]     a7;
    logic [31:0]     a0;
    logic [SW_W-1:0] sw_in;
    logic            confirm_btn;
    logic            stall;
    logic            wb_valid;
    logic [31:0]     wb_data;
    logic [31:0]     disp_data;
    logic            disp_update;
    logic            halted;

    int checks = 0;
    int errors = 0;

    ecall_io_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .SW_W           (SW_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ecall_valid(ecall_valid),
        .a7         (a7),
        .a0         (a0),
        .sw_in      (sw_in),
        .confirm_btn(confirm_btn),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .disp_data  (disp_data),
        .disp_update(disp_update),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] a7;
        logic [31:0] a0;
        logic [15:0] sw;
        logic        btn;
        logic        stall;
        logic        wbv;
        logic [31:0] wbd;
        logic [31:0] disp;
        logic        upd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ev, input logic [31:0] a7_v, input logic [31:0] a0_v,
                       input logic [15:0] sw, input logic btn, input logic st,
                       input logic wbv, input logic [31:0] wbd, input logic [31:0] disp,
                       input logic upd);
        vec_t v;
        v.ev = ev; v.a7 = a7_v; v.a0 = a0_v; v.sw = sw; v.btn = btn;
        v.stall = st; v.wbv = wbv; v.wbd = wbd; v.disp = disp; v.upd = upd;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [31:0] a7_v, input logic [31:0] a0_v,
                         input logic btn);
        ecall_valid = ev;
        a7          = a7_v;
        a0          = a0_v;
        confirm_btn = btn;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        sw_in = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        #1;
        check("post rst stall", {31'd0, stall}, 32'd0);
        check("post rst wb_valid", {31'd0, wb_valid}, 32'd0);
        check("post rst wb_data", wb_data, 32'd0);
        check("post rst disp", disp_data, 32'd0);
        check("post rst upd", {31'd0, disp_update}, 32'd0);
        tick();

        // ---- vector table: one entry per cycle; outputs observed that cycle ----
        //   ev  a7     a0            sw        btn stall wbv wbd       disp  upd
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  32'd0,    32'd0, 0);
        add(1, 32'd1,  BEEF,         16'h0000, 0,  0,    0,  32'd0,    32'd0, 0); // PRINT
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  32'd0,    BEEF,  1);
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  32'd0,    BEEF,  0);
        add(1, 32'd3,  32'h55,       16'h0000, 0,  0,    0,  32'd0,    BEEF,  0); // no-op code
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  32'd0,    BEEF,  0);
        // clean read
        add(1, 32'd5,  32'd0,        16'hFFFE, 0,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'hFFFE, 0,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'hFFFE, 1,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'hFFFE, 1,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'hFFFE, 1,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'hFFFE, 1,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'hFFFE, 0,  1,    0,  32'd0,    BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    1,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  RD_FFFE,  BEEF,  0);
        // stale button then bounce: high 2, low 1, high 4
        add(1, 32'd5,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 0,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 0,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h1234, 1,  1,    0,  RD_FFFE,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h0000, 1,  0,    1,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  RD_1234,  BEEF,  0);
        // bounce on the final debounce cycle, plus an ignored PRINT mid-wait
        add(1, 32'd5,  32'd0,        16'h8001, 0,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 0,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(1, 32'd1,  32'h1111_1111,16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 0,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 1,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h8001, 0,  1,    0,  RD_1234,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    1,  RD_8001,  BEEF,  0);
        add(0, 32'd0,  32'd0,        16'h0000, 0,  0,    0,  RD_8001,  BEEF,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ev, vecs[i].a7, vecs[i].a0, vecs[i].btn);
            sw_in = vecs[i].sw;
            #1;
            check($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].stall});
            check($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].wbv});
            check($sformatf("v%0d wb_data", i), wb_data, vecs[i].wbd);
            check($sformatf("v%0d disp_data", i), disp_data, vecs[i].disp);
            check($sformatf("v%0d disp_update", i), {31'd0, disp_update}, {31'd0, vecs[i].upd});
            check($sformatf("v%0d halted", i), {31'd0, halted}, 32'd0);
            tick();
        end

        // ---- EXIT, later ecall ignored, reset clears halted ----
        drive(1'b1, 32'd10, 32'd0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check("exit halted", {31'd0, halted}, 32'd1);
        check("exit stall", {31'd0, stall}, 32'd1);
        tick();
        drive(1'b1, 32'd1, 32'hCAFE_F00D, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check("halt disp kept", disp_data, BEEF);
        check("halt no upd", {31'd0, disp_update}, 32'd0);
        check("halt sticky", {31'd0, halted}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("halt rst halted", {31'd0, halted}, 32'd0);
        check("halt rst stall", {31'd0, stall}, 32'd0);
        check("halt rst disp", disp_data, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // ---- reset asserted while in DEBOUNCE ----
        sw_in = 16'h00AA;
        drive(1'b1, 32'd5, 32'd0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();                              // WAIT_REL -> WAIT_PRESS
        confirm_btn = 1'b1;
        repeat (3) tick();                   // now in DEBOUNCE, count 3
        check("mid pre stall", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid rst stall", {31'd0, stall}, 32'd0);
        check("mid rst wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mid rst wb_data", wb_data, 32'd0);
        tick();
        reset = 1'b1;
        // Button still held: an idle unit must not resume the abandoned read.
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("mid idle%0d stall", i), {31'd0, stall}, 32'd0);
            check($sformatf("mid idle%0d wb_valid", i), {31'd0, wb_valid}, 32'd0);
            tick();
        end
        drive(1'b1, 32'd1, 32'h0BAD_CAFE, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        check("mid idle print disp", disp_data, 32'h0BAD_CAFE);
        check("mid idle print upd", {31'd0, disp_update}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecall_io_unit.md
Name: ecall_io_unit

Overview:
- Services the `ecall` instruction for the single-cycle RV32 core.
- Sits beside the register-file/decoder and consumes the a7 and a0 values it supplies. Returns results via the core's write-back path.
- Drives the board I/O: 16 switches, a confirm button and a 32-bit display latch.
- Stalls the core (PC and register writes held) while a read service waits for the user.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive cycles confirm_btn must stay high to count as a press (board build overrides to 2_000_000).
- SW_W, 16, switch input width (1..32).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ecall_valid  in  1  current instruction == 32'h00000073.
- a7  in  32  service code (x17).
- a0  in  32  argument (x10).
- sw_in  in  SW_W  board switches, already synchronised.
- confirm_btn  in  1  confirm push-button, already synchronised, raw (bouncy).
- stall  out  1  hold PC and suppress regWrite.
- wb_valid  out  1  one-cycle strobe: write wb_data to x10 this cycle.
- wb_data  out  32  read result.
- disp_data  out  32  display latch.
- disp_update  out  1  one-cycle strobe when disp_data changes.
- halted  out  1  sticky program-exit flag.

Behaviour:
- Service codes: 1 = PRINT_INT, 5 = READ_INT, 10 = EXIT. Any other a7 value is a no-op: no stall, no strobes.
- Reset (reset==0, asynchronous) clears all registered state at once:
  - state=IDLE, debounce counter=0.
  - stall=0, wb_valid=0, wb_data=0, disp_data=0, disp_update=0, halted=0.
  - If reset asserts mid-wait, the pending read is abandoned and the core restarts.
- PRINT_INT:
  - In IDLE, with ecall_valid and a7==1: disp_data<=a0 at that clock edge, disp_update=1 for the following cycle.
  - No stall; the instruction completes in 1 cycle.
- READ_INT state machine (state register):
  - IDLE -> WAIT_REL when ecall_valid && a7==5. stall is asserted combinationally in that same cycle.
  - WAIT_REL: stays until confirm_btn==0, so a button held over from a previous read is not reused. Then -> WAIT_PRESS.
  - WAIT_PRESS: on confirm_btn==1, counter<=1 and -> DEBOUNCE.
  - DEBOUNCE: each cycle with confirm_btn==1, counter increments. If confirm_btn==0 before counter reaches DEBOUNCE_CYCLES: counter<=0, -> WAIT_PRESS. When counter==DEBOUNCE_CYCLES: wb_data<=extend(sw_in), -> WRITEBACK.
  - WRITEBACK: stall=0, wb_valid=1 for exactly this one cycle. The core retires the ecall and writes x10. -> IDLE.
  - stall=1 in every state except IDLE and WRITEBACK.
  - The counter saturates at DEBOUNCE_CYCLES and never wraps.
- EXIT: in IDLE, with ecall_valid and a7==10: -> HALT. halted=1 and stall=1 permanently until reset. All other ecalls are ignored in HALT.
- ecall_valid while not in IDLE is ignored; the instruction is held by stall anyway.
- Simultaneous events:
  - disp_update and wb_valid never assert together, because services are serialised.
  - A press aborted by a bounce on the final debounce cycle restarts the full DEBOUNCE_CYCLES count.
- extend(): see optional feature. When SW_W==32 no extension is applied.

Optional Feature:
- ECALL_SIGNED_READ_EN:
  - Defined: wb_data = sign-extension of sw_in from bit SW_W-1.
  - Undefined: zero-extension.
  - No other behaviour changes.

Decomposition:
- ecall_pkg holds:
  - service code constants SVC_PRINT_INT=1, SVC_READ_INT=5, SVC_EXIT=10;
  - state encoding IDLE, WAIT_REL, WAIT_PRESS, DEBOUNCE, WRITEBACK, HALT (3-bit);
  - the ecall opcode 32'h00000073.
- One sub-module, btn_debounce: counter plus stable-press detection, parameterised by DEBOUNCE_CYCLES. It exports a `pressed` pulse and a `released` level. The top-level FSM keeps the service sequencing.

Test Plan (DEBOUNCE_CYCLES=4, SW_W=16):
- Reset: reset=0 for 3 cycles, then release -> all outputs 0, state IDLE; stall=0 with no ecall.
- PRINT_INT: ecall_valid=1, a7=1, a0=32'hDEADBEEF -> next cycle disp_data=32'hDEADBEEF, disp_update=1 for 1 cycle, stall never 1.
- READ_INT clean press:
  - Setup: a7=5, sw_in=16'hFFFE, confirm_btn=1 held for 4 cycles.
  - Response: stall=1 from the ecall cycle through debounce. Then a single cycle with stall=0, wb_valid=1, wb_data=32'hFFFFFFFE with ECALL_SIGNED_READ_EN defined, or 32'h0000FFFE without.
- Bounce and stale button:
  - Setup: confirm_btn already 1 at the ecall, then released, then high 2 cycles, low 1, high 4.
  - Response: no wb_valid before the final 4-cycle run completes; exactly one wb_valid.
- EXIT then ecall: a7=10 -> halted=1, stall=1. A later ecall with a7=1 leaves disp_data unchanged. reset=0 clears halted.
- Reset mid-read: assert reset while in DEBOUNCE -> stall=0, wb_valid=0 immediately (asynchronous). After release, state is IDLE.
